// File: rtl/bru_pkg.sv
// Shared types and funct3 encodings for the branch resolve unit and its comparator.
package bru_pkg;

    typedef enum logic [1:0] {
        KIND_BRANCH = 2'd0,
        KIND_JAL    = 2'd1,
        KIND_JALR   = 2'd2,
        KIND_RSVD   = 2'd3
    } bru_kind_e;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    // Control fields of a request; widths of the data fields are module parameters.
    typedef struct packed {
        bru_kind_e  kind;
        logic [2:0] funct3;
        logic       pred_taken;
    } bru_req_t;

    typedef struct packed {
        logic taken;
        logic mispredict;
        logic illegal;
        logic misaligned;
    } bru_resp_t;

endpackage

// File: rtl/branch_compare.sv
// Combinational decode of a BRANCH funct3 into the branch condition and a legality flag.
module branch_compare
    import bru_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] lhs,
    input  logic [DATA_WIDTH-1:0] rhs,
    output logic                  cond,
    output logic                  legal
);

    logic eq_s;
    logic lt_s;
    logic ltu_s;

    assign eq_s  = (lhs == rhs);
    assign lt_s  = ($signed(lhs) < $signed(rhs));
    assign ltu_s = (lhs < rhs);

    // funct3 2 and 3 are reserved: never taken and flagged illegal.
    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        case (funct3)
            F3_BEQ:  cond = eq_s;
            F3_BNE:  cond = !eq_s;
            F3_BLT:  cond = lt_s;
            F3_BGE:  cond = !lt_s;
            F3_BLTU: cond = ltu_s;
            F3_BGEU: cond = !ltu_s;
            default: begin
                cond  = 1'b0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch/JAL/JALR resolution with a single-entry valid/ready output stage.
// Optional performance counters are built when BRU_PERF_EN is defined.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_kind,
    input  logic [2:0]            in_funct3,
    input  logic [DATA_WIDTH-1:0] in_lhs,
    input  logic [DATA_WIDTH-1:0] in_rhs,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    input  logic [ADDR_WIDTH-1:0] in_imm,
    input  logic                  in_pred_taken,
    input  logic [ADDR_WIDTH-1:0] in_pred_target,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_taken,
    output logic [ADDR_WIDTH-1:0] out_target,
    output logic [ADDR_WIDTH-1:0] out_link,
    output logic                  out_mispredict,
    output logic                  out_illegal,
    output logic                  out_misaligned
`ifdef BRU_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0]  perf_branches,
    output logic [CNT_WIDTH-1:0]  perf_mispredicts
`endif
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(3'd4);
    localparam logic [ADDR_WIDTH-1:0] JALR_MASK = ~ADDR_WIDTH'(1'b1);

    if (DATA_WIDTH < ADDR_WIDTH || CNT_WIDTH < 1) begin : g_bad_cfg
        $error("branch_resolve_unit: DATA_WIDTH must be >= ADDR_WIDTH and CNT_WIDTH >= 1");
    end

    bru_req_t               req_s;
    bru_resp_t              resp_s;
    logic                   cmp_cond_s;
    logic                   cmp_legal_s;
    logic                   legal_s;
    logic                   cond_s;
    logic [ADDR_WIDTH-1:0]  link_s;
    logic [ADDR_WIDTH-1:0]  pc_sum_s;
    logic [ADDR_WIDTH-1:0]  reg_sum_s;
    logic [ADDR_WIDTH-1:0]  taken_tgt_s;
    logic [ADDR_WIDTH-1:0]  next_pc_s;
    logic                   accept_s;
    logic                   transfer_s;

    logic                   valid_r;
    bru_resp_t              resp_r;
    logic [ADDR_WIDTH-1:0]  target_r;
    logic [ADDR_WIDTH-1:0]  link_r;

    branch_compare #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_compare (
        .funct3 (in_funct3),
        .lhs    (in_lhs),
        .rhs    (in_rhs),
        .cond   (cmp_cond_s),
        .legal  (cmp_legal_s)
    );

    assign req_s.kind       = bru_kind_e'(in_kind);
    assign req_s.funct3     = in_funct3;
    assign req_s.pred_taken = in_pred_taken;

    assign link_s    = in_pc + PC_STEP;
    assign pc_sum_s  = in_pc + in_imm;
    assign reg_sum_s = in_lhs[ADDR_WIDTH-1:0] + in_imm;

    // Kind decode: legality, condition and the would-be taken target.
    always_comb begin
        legal_s     = 1'b0;
        cond_s      = 1'b0;
        taken_tgt_s = pc_sum_s;
        case (req_s.kind)
            KIND_BRANCH: begin
                legal_s     = cmp_legal_s;
                cond_s      = cmp_cond_s;
                taken_tgt_s = pc_sum_s;
            end
            KIND_JAL: begin
                legal_s     = 1'b1;
                cond_s      = 1'b1;
                taken_tgt_s = pc_sum_s;
            end
            KIND_JALR: begin
                legal_s     = 1'b1;
                cond_s      = 1'b1;
                taken_tgt_s = reg_sum_s & JALR_MASK;
            end
            default: begin
                legal_s     = 1'b0;
                cond_s      = 1'b0;
                taken_tgt_s = pc_sum_s;
            end
        endcase
    end

    // Resolution against the prediction; taken already implies a legal request.
    always_comb begin
        resp_s.taken      = legal_s && cond_s;
        resp_s.illegal    = !legal_s;
        next_pc_s         = resp_s.taken ? taken_tgt_s : link_s;
        resp_s.mispredict = legal_s &&
                            ((resp_s.taken != req_s.pred_taken) ||
                             (resp_s.taken && (taken_tgt_s != in_pred_target)));
        resp_s.misaligned = resp_s.taken && taken_tgt_s[1];
    end

    assign in_ready   = !valid_r || out_ready;
    assign accept_s   = in_valid && in_ready;
    assign transfer_s = valid_r && out_ready;

    // Output stage: flush wins over a same-cycle accept; fields hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r  <= 1'b0;
            resp_r   <= '0;
            target_r <= '0;
            link_r   <= '0;
        end else if (flush) begin
            valid_r  <= 1'b0;
        end else if (accept_s) begin
            valid_r  <= 1'b1;
            resp_r   <= resp_s;
            target_r <= next_pc_s;
            link_r   <= link_s;
        end else if (transfer_s) begin
            valid_r  <= 1'b0;
        end
    end

    assign out_valid      = valid_r;
    assign out_taken      = resp_r.taken;
    assign out_target     = target_r;
    assign out_link       = link_r;
    assign out_mispredict = resp_r.mispredict;
    assign out_illegal    = resp_r.illegal;
    assign out_misaligned = resp_r.misaligned;

`ifdef BRU_PERF_EN
    logic                 branch_r;
    logic [CNT_WIDTH-1:0] branches_r;
    logic [CNT_WIDTH-1:0] mispredicts_r;

    // Tracks whether the held result came from a legal BRANCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_r <= 1'b0;
        end else if (accept_s && !flush) begin
            branch_r <= (req_s.kind == KIND_BRANCH) && legal_s;
        end
    end

    // Counters step on delivered transfers, including one completing under flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branches_r    <= '0;
            mispredicts_r <= '0;
        end else if (transfer_s) begin
            if (branch_r) begin
                branches_r <= branches_r + CNT_WIDTH'(1'b1);
            end
            if (resp_r.mispredict) begin
                mispredicts_r <= mispredicts_r + CNT_WIDTH'(1'b1);
            end
        end
    end

    assign perf_branches    = branches_r;
    assign perf_mispredicts = mispredicts_r;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized self-checking bench for branch_resolve_unit with a queue-based reference model.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [2:0]  in_funct3;
    logic [31:0] in_lhs;
    logic [31:0] in_rhs;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic        in_pred_taken;
    logic [31:0] in_pred_target;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic [31:0] out_target;
    logic [31:0] out_link;
    logic        out_mispredict;
    logic        out_illegal;
    logic        out_misaligned;
`ifdef BRU_PERF_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;
`endif

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic [31:0] link;
        logic        mispredict;
        logic        illegal;
        logic        misaligned;
        logic        is_branch;
    } exp_t;

    exp_t        exp_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_branches;
    logic [31:0] exp_mispredicts;

    branch_resolve_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .CNT_WIDTH  (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_kind        (in_kind),
        .in_funct3      (in_funct3),
        .in_lhs         (in_lhs),
        .in_rhs         (in_rhs),
        .in_pc          (in_pc),
        .in_imm         (in_imm),
        .in_pred_taken  (in_pred_taken),
        .in_pred_target (in_pred_target),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_taken      (out_taken),
        .out_target     (out_target),
        .out_link       (out_link),
        .out_mispredict (out_mispredict),
        .out_illegal    (out_illegal),
        .out_misaligned (out_misaligned)
`ifdef BRU_PERF_EN
        ,
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural reference: direct reading of the ISA rules.
    function automatic exp_t ref_model(input logic [1:0] kind, input logic [2:0] f3,
                                       input logic [31:0] lhs, input logic [31:0] rhs,
                                       input logic [31:0] pc, input logic [31:0] imm,
                                       input logic pt, input logic [31:0] ptgt);
        exp_t        e;
        logic        legal;
        logic        cond;
        logic [31:0] tgt;
        int          sl;
        int          sr;
        sl    = int'(lhs);
        sr    = int'(rhs);
        legal = 1'b1;
        cond  = 1'b0;
        tgt   = pc + imm;
        if (kind == 2'd0) begin
            if (f3 == 3'd0)      cond = (lhs == rhs);
            else if (f3 == 3'd1) cond = (lhs != rhs);
            else if (f3 == 3'd4) cond = (sl < sr);
            else if (f3 == 3'd5) cond = (sl >= sr);
            else if (f3 == 3'd6) cond = (lhs < rhs);
            else if (f3 == 3'd7) cond = (lhs >= rhs);
            else                 legal = 1'b0;
        end else if (kind == 2'd1) begin
            cond = 1'b1;
        end else if (kind == 2'd2) begin
            cond = 1'b1;
            tgt  = (lhs + imm) & 32'hFFFF_FFFE;
        end else begin
            legal = 1'b0;
        end
        e.taken      = legal && cond;
        e.link       = pc + 32'd4;
        e.target     = e.taken ? tgt : e.link;
        e.illegal    = !legal;
        e.mispredict = legal && ((e.taken != pt) || (e.taken && (e.target != ptgt)));
        e.misaligned = e.taken && e.target[1];
        e.is_branch  = (kind == 2'd0) && legal;
        return e;
    endfunction

    task automatic drive(input logic [1:0] kind, input logic [2:0] f3,
                         input logic [31:0] lhs, input logic [31:0] rhs,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic pt, input logic [31:0] ptgt);
        in_kind        = kind;
        in_funct3      = f3;
        in_lhs         = lhs;
        in_rhs         = rhs;
        in_pc          = pc;
        in_imm         = imm;
        in_pred_taken  = pt;
        in_pred_target = ptgt;
    endtask

    task automatic drive_random();
        exp_t e;
        drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom,
              ($urandom_range(0, 3) == 0) ? in_lhs : $urandom,
              $urandom & 32'hFFFF_FFFC, $urandom, 1'($urandom_range(0, 1)), $urandom);
        if ($urandom_range(0, 3) == 0) in_rhs = in_lhs;
        e = ref_model(in_kind, in_funct3, in_lhs, in_rhs, in_pc, in_imm, in_pred_taken, in_pred_target);
        if ($urandom_range(0, 1) == 1) in_pred_target = e.target;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, "_valid"}, 64'(out_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check_val({tag, "_taken"},  64'(out_taken),      64'(exp_q[0].taken));
            check_val({tag, "_target"}, 64'(out_target),     64'(exp_q[0].target));
            check_val({tag, "_link"},   64'(out_link),       64'(exp_q[0].link));
            check_val({tag, "_mispr"},  64'(out_mispredict), 64'(exp_q[0].mispredict));
            check_val({tag, "_ill"},    64'(out_illegal),    64'(exp_q[0].illegal));
            check_val({tag, "_misal"},  64'(out_misaligned), 64'(exp_q[0].misaligned));
        end
`ifdef BRU_PERF_EN
        check_val({tag, "_pbr"}, 64'(perf_branches),    64'(exp_branches));
        check_val({tag, "_pmp"}, 64'(perf_mispredicts), 64'(exp_mispredicts));
`endif
    endtask

    // One clock: check in_ready, advance the model at the edge, check outputs at the next negedge.
    task automatic step(input string tag);
        logic exp_ready;
        logic acc;
        logic xfer;
        exp_t e;
        #1;
        exp_ready = (exp_q.size() == 0) || out_ready;
        check_val({tag, "_in_ready"}, 64'(in_ready), 64'(exp_ready));
        acc  = in_valid && exp_ready;
        xfer = (exp_q.size() != 0) && out_ready;
        e    = ref_model(in_kind, in_funct3, in_lhs, in_rhs, in_pc, in_imm, in_pred_taken, in_pred_target);
        @(posedge clk);
        if (xfer) begin
            if (exp_q[0].is_branch)  exp_branches    = exp_branches + 32'd1;
            if (exp_q[0].mispredict) exp_mispredicts = exp_mispredicts + 32'd1;
            void'(exp_q.pop_front());
        end
        if (flush)    exp_q.delete();
        else if (acc) exp_q.push_back(e);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_valid"},  64'(out_valid),      64'd0);
        check_val({tag, "_taken"},  64'(out_taken),      64'd0);
        check_val({tag, "_target"}, 64'(out_target),     64'd0);
        check_val({tag, "_link"},   64'(out_link),       64'd0);
        check_val({tag, "_flags"},  64'({out_mispredict, out_illegal, out_misaligned}), 64'd0);
        check_val({tag, "_ready"},  64'(in_ready),       64'd1);
`ifdef BRU_PERF_EN
        check_val({tag, "_perf"},   64'({perf_branches, perf_mispredicts}), 64'd0);
`endif
    endtask

    initial begin
        rst_n           = 1'b0;
        in_valid        = 1'b0;
        out_ready       = 1'b1;
        flush           = 1'b0;
        exp_branches    = 32'd0;
        exp_mispredicts = 32'd0;
        drive(2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: signed vs unsigned compare of the same operands.
        in_valid = 1'b1;
        drive(2'd0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0, 32'h0);
        step("blt");
        check_val("blt_taken",  64'(out_taken),      64'd1);
        check_val("blt_target", 64'(out_target),     64'h120);
        check_val("blt_mispr",  64'(out_mispredict), 64'd1);
        drive(2'd0, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0, 32'h0);
        step("bltu");
        check_val("bltu_taken",  64'(out_taken),      64'd0);
        check_val("bltu_target", 64'(out_target),     64'h104);
        check_val("bltu_mispr",  64'(out_mispredict), 64'd0);
        drive(2'd2, 3'd0, 32'h1003, 32'd0, 32'h200, 32'h0, 1'b1, 32'h1002);
        step("jalr");
        check_val("jalr_target", 64'(out_target),     64'h1002);
        check_val("jalr_link",   64'(out_link),       64'h204);
        check_val("jalr_misal",  64'(out_misaligned), 64'd1);
        check_val("jalr_mispr",  64'(out_mispredict), 64'd0);
        drive(2'd0, 3'd2, 32'd5, 32'd5, 32'h300, 32'h40, 1'b1, 32'h340);
        step("ill");
        check_val("ill_flag",  64'(out_illegal),    64'd1);
        check_val("ill_taken", 64'(out_taken),      64'd0);
        check_val("ill_mispr", 64'(out_mispredict), 64'd0);
        drive(2'd3, 3'd0, 32'd5, 32'd5, 32'h400, 32'h40, 1'b1, 32'h440);
        step("rsvd");
        check_val("rsvd_flag", 64'(out_illegal), 64'd1);

        // Back-pressure: three stalled cycles, then drain with fresh requests.
        drive_random();
        step("load");
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            step("stall");
            check_val("stall_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_random();
            step("drain");
        end

        // Flush while a transfer completes and a new request is offered.
        drive_random();
        flush = 1'b1;
        step("flush");
        check_val("flush_valid", 64'(out_valid), 64'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        step("post_flush");

        // Randomized traffic with one asynchronous reset pulse in the middle.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            drive_random();
            step("rand");
            if (i == 1500) begin
                in_valid  = 1'b1;
                out_ready = 1'b0;
                flush     = 1'b0;
                drive_random();
                step("pre_rst");
                #2;
                rst_n = 1'b0;
                #1;
                check_reset_state("mid_rst");
                exp_q.delete();
                exp_branches    = 32'd0;
                exp_mispredicts = 32'd0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        step("final");
        step("idle");
        check_val("idle_valid", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
